data_mem_resp: RTL

Data-memory responder for the load/store datapath. Consumes the `mem_read`/`mem_write` strobes produced by the opcode decoder, together with an address and store data, over a valid/ready request handshake. Serves each access from an internal word array after a fixed, parameterised wait. Returns a one-cycle response carrying load data or a store acknowledge.

---
 rtl/data_mem_resp.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: data-memory responder for the load/store datapath.
// Accepts one request at a time over a valid/ready handshake, waits a fixed
// number of cycles, then returns a one-cycle load response, store acknowledge
// or error response.
//
// Parameters: ADDR_W (word address width), DATA_W (word width),
//             WAIT_CYCLES (access wait states, 0..15).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   mem_read, mem_write  request type, sampled on handshake
//   addr, wdata          word address and store data, sampled on handshake
//   resp_valid           one-cycle response pulse
//   resp_write           1 = store ack, 0 = load response (qualifies resp_valid)
//   resp_err             error response (qualifies resp_valid)
//   rdata                load data, held between load responses
//   par_inject           inverts the stored parity bit of a store
//                        (only with DMEM_PARITY_EN)
// Optional feature macro: DMEM_PARITY_EN (per-word even parity + check).
module data_mem_resp #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic              resp_write,
  output logic              resp_err,
`ifdef DMEM_PARITY_EN
  input  logic              par_inject,
`endif
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              rd_q, wr_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic hs, legal, illegal, last_wait, direct, commit_acc, acc_rd, acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign hs        = req_valid & req_ready;
  assign legal     = mem_read ^ mem_write;
  assign illegal   = mem_read & mem_write;
  assign last_wait = (state == S_WAIT) && (cnt == 4'd0);
  // With no wait states the access happens on the handshake edge itself,
  // so it uses the live inputs instead of the captured copies.
  assign direct     = hs & legal & (WAIT_CYCLES == 0);
  assign commit_acc = last_wait | direct;
  assign acc_rd     = direct ? mem_read  : rd_q;
  assign acc_wr     = direct ? mem_write : wr_q;
  assign acc_addr   = direct ? addr      : addr_q;
  assign acc_wdata  = direct ? wdata     : wdata_q;

`ifdef DMEM_PARITY_EN
  logic             inj_q, acc_inj, par_bad;
  logic [DEPTH-1:0] par_mem;
  assign acc_inj = direct ? par_inject : inj_q;
  // Even parity: stored bit equals XOR of the data bits.
  assign par_bad = (^mem[acc_addr]) ^ par_mem[acc_addr];
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (hs) begin
        if (illegal)                         state_nxt = S_RESP;
        else if (legal)                      state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt == 4'd0)               state_nxt = S_RESP;
      S_RESP:                                state_nxt = S_IDLE;
      default:                               state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_write = (state == S_RESP) & wr_q & ~rd_q;
    resp_err   = (state == S_RESP) & err_q;
  end

  // Request capture, wait counter, load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
`ifdef DMEM_PARITY_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      if (hs) begin
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        err_q   <= illegal;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= CNT_INIT;
`ifdef DMEM_PARITY_EN
        inj_q   <= par_inject;
`endif
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit_acc && acc_rd) begin
        rdata <= mem[acc_addr];
`ifdef DMEM_PARITY_EN
        err_q <= par_bad;
`endif
      end
    end
  end

  // Word array; a store commits on the edge entering RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef DMEM_PARITY_EN
      par_mem <= '0;
`endif
    end else if (commit_acc && acc_wr) begin
      mem[acc_addr] <= acc_wdata;
`ifdef DMEM_PARITY_EN
      par_mem[acc_addr] <= (^acc_wdata) ^ acc_inj;
`endif
    end
  end

endmodule
